// File: rtl/delay_slot_arbiter_pkg.sv
// Shared definitions for the delay-slot arbiter and other clients of the programmable delay timer.
package delay_slot_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FIRE    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int DEFAULT_DELAY = 10;
  localparam int DEFAULT_W     = 4;

endpackage

// File: rtl/delay_slot_arbiter_if.sv
// Request/grant/strobe bundle between the requesters (master) and the delay-slot arbiter (slave).
interface delay_slot_arbiter_if #(
  parameter int N  = 4,
  parameter int IW = 2
);
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          fire;
  logic [N-1:0]  ack;

  modport master (output req, input grant, grant_id, busy, fire, ack);
  modport slave  (input req, output grant, grant_id, busy, fire, ack);
endinterface

// File: rtl/delay_slot_arbiter_req_sync.sv
// Two-flop synchroniser for one asynchronous request level; two out_clk edges of latency.
module req_sync (
  input  logic out_clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge out_clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/delay_slot_arbiter.sv
// Round-robin owner of one delay timer: grant 3 edges after req, fire DELAY cycles after grant,
// ack held until the owner drops req; non-owners simply wait while the timer is busy.
module delay_slot_arbiter
  import delay_slot_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IW    = 2,
  parameter int DELAY = DEFAULT_DELAY,
  parameter int W     = DEFAULT_W
) (
  input logic                 out_clk,
  input logic                 reset,
  delay_slot_arbiter_if.slave bus
);

  logic [N-1:0]  rs;
  arb_state_t    state, state_n;
  logic [W-1:0]  cnt, cnt_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] owner, owner_n;
  logic [N-1:0]  grant, grant_n;
  logic [N-1:0]  ack, ack_n;
  logic          fire, fire_n;
  logic          busy;
  logic [IW-1:0] pick;

  for (genvar i = 0; i < N; i++) begin : g_sync
    req_sync u_sync (
      .out_clk (out_clk),
      .reset   (reset),
      .d       (bus.req[i]),
      .q       (rs[i])
    );
  end

  // First set request at or after p, wrapping N-1 -> 0.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [2*N-1:0] rot;
    logic           found;
    int             sum;
    logic [IW-1:0]  idx;
    rot   = {r, r} >> p;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = int'(p) + k;
        if (sum >= N) sum = sum - N;
        idx   = IW'(sum);
      end
    end
    return idx;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] o);
    return (int'(o) == N - 1) ? '0 : o + 1'b1;
  endfunction

  assign pick = rr_pick(rs, ptr);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    owner_n = owner;
    grant_n = grant;
    ack_n   = ack;
    fire_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|rs) begin
          owner_n = pick;
          grant_n = N'(1) << pick;
          cnt_n   = '0;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An owner that withdraws before the strobe forfeits its turn silently.
        if (!rs[owner]) begin
          grant_n = '0;
          owner_n = '0;
          cnt_n   = '0;
          ptr_n   = next_ptr(owner);
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == W'(DELAY - 1)) begin
            fire_n  = 1'b1;
            ack_n   = grant;
            state_n = ST_FIRE;
          end
        end
      end
      ST_FIRE: begin
        state_n = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!rs[owner]) begin
          ack_n   = '0;
          grant_n = '0;
          owner_n = '0;
          ptr_n   = next_ptr(owner);
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge out_clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      owner <= '0;
      grant <= '0;
      ack   <= '0;
      fire  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      grant <= grant_n;
      ack   <= ack_n;
      fire  <= fire_n;
      busy  <= |grant_n;
    end
  end

  assign bus.grant    = grant;
  assign bus.grant_id = owner;
  assign bus.busy     = busy;
  assign bus.fire     = fire;
  assign bus.ack      = ack;

endmodule

// File: doc/delay_slot_arbiter.md
# delay_slot_arbiter

Round-robin arbiter sharing one programmable delay timer among N asynchronous four-phase requesters. Each request line is resynchronised into the out_clk domain and queued for the timer. The granted requester receives a one-cycle `fire` strobe DELAY cycles after grant, and a held `ack`. It sits between the host/peripheral request sources and the sequencer that consumes the timed strobe.

## Interface
- N, 4, number of requesters (2..8)
- IW, 2, width of `grant_id`; equals clog2(N)
- DELAY, 10, out_clk cycles from grant rising to `fire`; must be ≥1
- W, 4, timer counter width; must hold DELAY
- out_clk  input  1  destination clock; all state on rising edge
- reset  input  1  reset, synchronous, active-high; clock out_clk
- req  input  N  per-requester request; asynchronous to out_clk, level, four-phase
- grant  output  N  one-hot owner of the timer; all-zero when idle
- grant_id  output  IW  binary index of current owner; 0 when idle
- busy  output  1  timer owned (any grant bit set)
- fire  output  1  one-cycle strobe at end of delay
- ack  output  N  per-requester acknowledge; held until that request drops

## Operation
- Each `req[i]` passes through a two-flop synchroniser; only the synchronised value `rs[i]` is used.
- FSM states: IDLE, WAIT, FIRE, RELEASE.
- IDLE: if any `rs` is set, pick the first set bit at or after `ptr` (wrapping N-1→0). Register `grant`/`grant_id`, clear the counter, go to WAIT. If no `rs` is set, stay in IDLE.
- WAIT: counter increments each cycle.
  - If counter==DELAY-1, go to FIRE.
  - If `rs[owner]` drops first (abort), go to IDLE. Clear `grant`, no `fire`, no `ack`, and advance `ptr` to owner+1.
- FIRE: `fire`=1 for this cycle only. Set `ack[owner]`, go to RELEASE.
- RELEASE: hold `ack[owner]` and `grant`. When `rs[owner]`==0, clear `ack[owner]` and `grant`, set `ptr`=owner+1 mod N, go to IDLE.
- Requesters must not raise `req` again before seeing their `ack` low. A second `req` from a non-owner simply waits.
- At most one `grant` bit and at most one `ack` bit are set at any time. `ack` is only ever set for the current owner.

## Timing
- Reset (synchronous): state IDLE, `ptr`=0, counter=0, synchroniser flops 0, `grant`=0, `grant_id`=0, `busy`=0, `fire`=0, `ack`=0.
- Reset mid-operation (any state) takes effect the next edge, with the same values as above. A pending `fire` is dropped.
- `req[i]` sampled high at edge k → `rs[i]` high after edge k+1 → `grant` high after edge k+2, if the arbiter is IDLE.
- `grant` rising edge → `fire` high DELAY cycles later. `ack` rises on that same edge and stays high.
- `req` low sampled at edge m → `ack`/`grant` low after edge m+2.
- Back-to-back grants: after RELEASE→IDLE, the next grant is registered on the following edge. Minimum one idle cycle between owners.
- Simultaneous requests in IDLE: the round-robin order from `ptr` decides the owner. Others keep waiting with no loss.
- `busy`, `grant`, `grant_id`, `fire` and `ack` are all registered; none depend combinationally on `req`.

## Structure
- Shared package/header: FSM state encodings (2-bit), plus DELAY/W default constants used by other timer clients.
- One natural sub-module, `req_sync`: a 1-bit two-flop synchroniser with synchronous reset, instantiated N times.
- The round-robin priority pick is a function inside the arbiter, not a separate module.

## Test plan
- Single request (N=4, DELAY=10): `req[2]` raised → `grant`=4'b0100 and `grant_id`=2 three edges later. `fire` comes 10 cycles after grant, with `ack[2]`=1. Dropping `req[2]` clears `ack` and `grant` 2 edges later.
- Contention: raise `req[0]`, `req[1]` and `req[3]` on the same edge with `ptr`=0. Service order must be 0,1,3. Each gets exactly one `fire`, and there is ≥1 idle cycle between grants.
- Wrap-around: with `ptr`=3 after serving 2, raise `req[0]` and `req[3]` together. Owner 3 is served first, then 0.
- Abort: drop `req[1]` at 5 cycles into WAIT. No `fire`, `ack[1]` never rises, `grant` clears, and the next pending requester (`req[2]`) is granted.
- Reset mid-WAIT and mid-RELEASE: assert reset for 1 cycle. All outputs are 0 the next edge and no stray `fire`. With `req[3]` still high, it is re-granted from `ptr`=0 arbitration.
- Held ack: keep `req[0]` high 20 cycles past `fire`. `ack[0]` and `grant` stay high with no second `fire`, and `req[1]` stays ungranted until release.
